// File: rtl/issue_scoreboard_if.sv
// Decode/writeback/execute/memory-port signal bundle for issue_scoreboard_ctrl.
// The master drives decode and ALU writeback; the slave (controller) drives the rest.
interface issue_scoreboard_if;
    logic       dec_valid;
    logic [3:0] dec_opcode;
    logic [3:0] dec_dest;
    logic [3:0] dec_src1;
    logic [3:0] dec_src2;
    logic [7:0] dec_memAddr;
    logic       wb_valid;
    logic [3:0] wb_reg;
    logic       inuse1;
    logic       inuse2;
    logic       stall;
    logic       ex_valid;
    logic [3:0] ex_opcode;
    logic [3:0] ex_destReg;
    logic       ld_wb_valid;
    logic [3:0] ld_wb_reg;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic       mem_busy;

    modport master (
        output dec_valid, dec_opcode, dec_dest, dec_src1, dec_src2, dec_memAddr,
        output wb_valid, wb_reg,
        input  inuse1, inuse2, stall, ex_valid, ex_opcode, ex_destReg,
        input  ld_wb_valid, ld_wb_reg, mem_addr, mem_we, mem_busy
    );

    modport slave (
        input  dec_valid, dec_opcode, dec_dest, dec_src1, dec_src2, dec_memAddr,
        input  wb_valid, wb_reg,
        output inuse1, inuse2, stall, ex_valid, ex_opcode, ex_destReg,
        output ld_wb_valid, ld_wb_reg, mem_addr, mem_we, mem_busy
    );
endinterface

// File: rtl/issue_scoreboard_ctrl.sv
// Issue controller, register scoreboard and single memory-port sequencer.
// Optional macro ISSUE_PERF_CNT_EN adds saturating stall_count/issue_count outputs.
module issue_scoreboard_ctrl #(
    parameter int NREGS   = 16,
    parameter int MEM_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    issue_scoreboard_if.slave bus
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [15:0] stall_count,
    output logic [15:0] issue_count
`endif
);
    localparam logic [3:0] OP_LOAD  = 4'b1110;
    localparam logic [3:0] OP_STORE = 4'b1111;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} mem_state_t;

    function automatic logic [NREGS-1:0] reg_mask(input logic [3:0] idx);
        logic [NREGS-1:0] m;
        m      = {NREGS{1'b0}};
        m[idx] = 1'b1;
        return m;
    endfunction

    mem_state_t       state_r, state_next_s;
    logic [NREGS-1:0] busy_r, busy_next_s, clear_view_s;
    logic [3:0]       cnt_r, ld_reg_r;
    logic             is_load_r, mem_we_r;
    logic [7:0]       mem_addr_r;
    logic             ex_valid_r;
    logic [3:0]       ex_opcode_r, ex_dest_r;
    logic             is_load_op_s, is_store_op_s, is_mem_op_s;
    logic             final_beat_s, ld_wb_valid_s, mem_busy_s;
    logic             hazard_s, issue_s, stall_s;

    assign is_load_op_s  = (bus.dec_opcode == OP_LOAD);
    assign is_store_op_s = (bus.dec_opcode == OP_STORE);
    assign is_mem_op_s   = is_load_op_s | is_store_op_s;
    assign mem_busy_s    = (state_r == ST_BUSY);
    assign final_beat_s  = mem_busy_s & (cnt_r == 4'd0);
    assign ld_wb_valid_s = final_beat_s & is_load_r & ~rst;

    // Scoreboard as seen this cycle, with same-cycle writebacks already retired
    always_comb begin
        clear_view_s = busy_r;
        if (bus.wb_valid) begin
            clear_view_s = clear_view_s & ~reg_mask(bus.wb_reg);
        end else begin
            clear_view_s = clear_view_s;
        end
        if (ld_wb_valid_s) begin
            clear_view_s = clear_view_s & ~reg_mask(ld_reg_r);
        end else begin
            clear_view_s = clear_view_s;
        end
    end

    // Hazard detection per opcode class
    always_comb begin
        hazard_s = 1'b0;
        case (bus.dec_opcode)
            OP_LOAD:  hazard_s = clear_view_s[bus.dec_dest] | mem_busy_s;
            OP_STORE: hazard_s = clear_view_s[bus.dec_dest] | mem_busy_s;
            default:  hazard_s = clear_view_s[bus.dec_src1] | clear_view_s[bus.dec_src2]
                               | clear_view_s[bus.dec_dest];
        endcase
    end

    assign stall_s = bus.dec_valid & hazard_s & ~rst;
    assign issue_s = bus.dec_valid & ~hazard_s & ~rst;

    // Next scoreboard: clears first, then a new producer's set wins
    always_comb begin
        busy_next_s = clear_view_s;
        if (issue_s && !is_store_op_s) begin
            busy_next_s = busy_next_s | reg_mask(bus.dec_dest);
        end else begin
            busy_next_s = busy_next_s;
        end
    end

    // Memory port next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s && is_mem_op_s) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, scoreboard and execute-stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            busy_r      <= {NREGS{1'b0}};
            ex_valid_r  <= 1'b0;
            ex_opcode_r <= 4'd0;
            ex_dest_r   <= 4'd0;
        end else begin
            state_r    <= state_next_s;
            busy_r     <= busy_next_s;
            ex_valid_r <= issue_s;
            if (issue_s) begin
                ex_opcode_r <= bus.dec_opcode;
                ex_dest_r   <= bus.dec_dest;
            end
        end
    end

    // Memory-op context captured at issue; counter runs down while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= 4'd0;
            mem_addr_r <= 8'd0;
            mem_we_r   <= 1'b0;
            ld_reg_r   <= 4'd0;
            is_load_r  <= 1'b0;
        end else if (!mem_busy_s && issue_s && is_mem_op_s) begin
            cnt_r      <= 4'(MEM_LAT - 1);
            mem_addr_r <= bus.dec_memAddr;
            mem_we_r   <= is_store_op_s;
            ld_reg_r   <= bus.dec_dest;
            is_load_r  <= is_load_op_s;
        end else if (mem_busy_s) begin
            if (cnt_r == 4'd0) begin
                mem_we_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [15:0] stall_count_r, issue_count_r;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= 16'd0;
            issue_count_r <= 16'd0;
        end else begin
            if (stall_s && stall_count_r != 16'hFFFF) begin
                stall_count_r <= stall_count_r + 16'd1;
            end
            if (issue_s && issue_count_r != 16'hFFFF) begin
                issue_count_r <= issue_count_r + 16'd1;
            end
        end
    end

    assign stall_count = stall_count_r;
    assign issue_count = issue_count_r;
`endif

    assign bus.inuse1      = clear_view_s[bus.dec_src1];
    assign bus.inuse2      = clear_view_s[bus.dec_src2];
    assign bus.stall       = stall_s;
    assign bus.ex_valid    = ex_valid_r;
    assign bus.ex_opcode   = ex_opcode_r;
    assign bus.ex_destReg  = ex_dest_r;
    assign bus.ld_wb_valid = ld_wb_valid_s;
    assign bus.ld_wb_reg   = ld_reg_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_busy    = mem_busy_s;
endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Directed bench for issue_scoreboard_ctrl: issue/load-writeback events go through
// expectation queues checked by a monitor; combinational flags are checked inline.
module tb_issue_scoreboard_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [7:0] ex_q[$];
    logic [3:0] ld_q[$];

    issue_scoreboard_if bus();

`ifdef ISSUE_PERF_CNT_EN
    logic [15:0] stall_count, issue_count;
    issue_scoreboard_ctrl #(.NREGS(16), .MEM_LAT(3)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .stall_count(stall_count), .issue_count(issue_count)
    );
`else
    issue_scoreboard_ctrl #(.NREGS(16), .MEM_LAT(3)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic wv, input logic [3:0] wr);
        bus.dec_valid   = v;
        bus.dec_opcode  = instr[15:12];
        bus.dec_dest    = instr[11:8];
        bus.dec_src1    = instr[7:4];
        bus.dec_src2    = instr[3:0];
        bus.dec_memAddr = instr[7:0];
        bus.wb_valid    = wv;
        bus.wb_reg      = wr;
        #1;
    endtask

    // Monitor: every presented issue or load writeback must match the oldest expectation
    always @(negedge clk) begin
        logic [7:0] e8;
        logic [3:0] e4;
        if (bus.ex_valid === 1'b1) begin
            checks++;
            if (ex_q.size() == 0) begin
                failures++;
                $display("FAIL ex_unexpected: got op=%h dest=%h expected no issue at %0t",
                         bus.ex_opcode, bus.ex_destReg, $time);
            end else begin
                e8 = ex_q.pop_front();
                if ({bus.ex_opcode, bus.ex_destReg} !== e8) begin
                    failures++;
                    $display("FAIL ex_issue: got %h expected %h at %0t",
                             {bus.ex_opcode, bus.ex_destReg}, e8, $time);
                end
            end
        end
        if (bus.ld_wb_valid === 1'b1) begin
            checks++;
            if (ld_q.size() == 0) begin
                failures++;
                $display("FAIL ld_wb_unexpected: got reg=%h expected no pulse at %0t",
                         bus.ld_wb_reg, $time);
            end else begin
                e4 = ld_q.pop_front();
                if (bus.ld_wb_reg !== e4) begin
                    failures++;
                    $display("FAIL ld_wb_reg: got %h expected %h at %0t", bus.ld_wb_reg, e4, $time);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 4'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ex_valid", {15'd0, bus.ex_valid}, 16'd0);
        chk("rst_ex_fields", {8'd0, bus.ex_opcode, bus.ex_destReg}, 16'd0);
        chk("rst_mem", {7'd0, bus.mem_busy, bus.mem_addr}, 16'd0);

        // RAW stall on R3, released by a same-cycle writeback
        drive(1'b1, 16'h2331, 1'b0, 4'd0);
        chk("raw_first_stall", {15'd0, bus.stall}, 16'd0);
        ex_q.push_back(8'h23);
        tick();
        drive(1'b1, 16'h4235, 1'b0, 4'd0);
        chk("raw_inuse1", {15'd0, bus.inuse1}, 16'd1);
        chk("raw_inuse2", {15'd0, bus.inuse2}, 16'd0);
        chk("raw_stall", {15'd0, bus.stall}, 16'd1);
        tick();
        chk("raw_stall_hold", {15'd0, bus.stall}, 16'd1);
        drive(1'b1, 16'h4235, 1'b1, 4'd3);
        chk("raw_wb_release", {15'd0, bus.stall}, 16'd0);
        chk("raw_wb_inuse1", {15'd0, bus.inuse1}, 16'd0);
        ex_q.push_back(8'h42);
        tick();
        drive(1'b0, 16'h0000, 1'b1, 4'd2);
        tick();

        // Load latency, with an overlapping ALU issue
        drive(1'b1, 16'hE7EE, 1'b0, 4'd0);
        chk("ld_issue_stall", {15'd0, bus.stall}, 16'd0);
        ex_q.push_back(8'hE7);
        ld_q.push_back(4'd7);
        tick();
        drive(1'b1, 16'h2121, 1'b0, 4'd0);
        chk("ld_c1", {6'd0, bus.mem_we, bus.mem_busy, bus.mem_addr}, 16'h01EE);
        chk("ld_c1_pulse", {15'd0, bus.ld_wb_valid}, 16'd0);
        chk("overlap_stall", {15'd0, bus.stall}, 16'd0);
        ex_q.push_back(8'h21);
        tick();
        drive(1'b0, 16'h0070, 1'b1, 4'd1);
        chk("ld_c2", {14'd0, bus.mem_busy, bus.ld_wb_valid}, 16'd2);
        chk("ld_c2_r7_busy", {15'd0, bus.inuse1}, 16'd1);
        tick();
        drive(1'b0, 16'h0070, 1'b0, 4'd0);
        chk("ld_c3", {14'd0, bus.mem_busy, bus.ld_wb_valid}, 16'd3);
        chk("ld_c3_reg", {12'd0, bus.ld_wb_reg}, 16'd7);
        chk("ld_c3_inuse1", {15'd0, bus.inuse1}, 16'd0);
        tick();
        chk("ld_done_busy", {15'd0, bus.mem_busy}, 16'd0);
        chk("ld_done_r7", {15'd0, bus.inuse1}, 16'd0);

        // Port conflict: store waits out the load, then writes
        drive(1'b1, 16'hE7EE, 1'b0, 4'd0);
        ex_q.push_back(8'hE7);
        ld_q.push_back(4'd7);
        tick();
        drive(1'b1, 16'hF5EF, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            chk("st_conflict_stall", {15'd0, bus.stall}, 16'd1);
            tick();
        end
        chk("st_issue_stall", {15'd0, bus.stall}, 16'd0);
        ex_q.push_back(8'hF5);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 4'd0);
        chk("st_port", {6'd0, bus.mem_we, bus.mem_busy, bus.mem_addr}, 16'h03EF);
        tick();
        tick();
        chk("st_c3_no_pulse", {15'd0, bus.ld_wb_valid}, 16'd0);
        tick();
        chk("st_done", {14'd0, bus.mem_we, bus.mem_busy}, 16'd0);

        // Set/clear collision on R3
        drive(1'b1, 16'h2331, 1'b0, 4'd0);
        ex_q.push_back(8'h23);
        tick();
        drive(1'b1, 16'h5300, 1'b1, 4'd3);
        chk("coll_stall", {15'd0, bus.stall}, 16'd0);
        ex_q.push_back(8'h53);
        tick();
        drive(1'b0, 16'h0030, 1'b0, 4'd0);
        chk("coll_r3_busy", {15'd0, bus.inuse1}, 16'd1);
        drive(1'b0, 16'h0030, 1'b1, 4'd3);
        tick();
        drive(1'b0, 16'h0030, 1'b0, 4'd0);
        chk("coll_r3_cleared", {15'd0, bus.inuse1}, 16'd0);

        // Reset in the second busy cycle of a load
        drive(1'b1, 16'hE7EE, 1'b0, 4'd0);
        ex_q.push_back(8'hE7);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 4'd0);
        tick();
        rst = 1'b1;
        drive(1'b1, 16'hF5EF, 1'b0, 4'd0);
        chk("rst_stall_low", {15'd0, bus.stall}, 16'd0);
        chk("rst_no_pulse", {15'd0, bus.ld_wb_valid}, 16'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0070, 1'b0, 4'd0);
        chk("rst_mid_mem", {7'd0, bus.mem_busy, bus.mem_addr}, 16'd0);
        chk("rst_mid_r7", {15'd0, bus.inuse1}, 16'd0);
        chk("rst_mid_ex", {15'd0, bus.ex_valid}, 16'd0);
        for (int i = 0; i < 4; i++) tick();

        chk("ex_q_drained", 16'(ex_q.size()), 16'd0);
        chk("ld_q_drained", 16'(ld_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/issue_scoreboard_ctrl.md
Name: issue_scoreboard_ctrl

Overview:
Issue controller and register scoreboard for the 3-stage pipeline. It sits between decode and execute.
- Tracks which of the 16 architectural registers have a pending write, and drives the inuse1/inuse2 flags consumed by the register-file read path.
- Stalls fetch/decode on RAW/WAW hazards.
- Owns the single memory port, sequencing multi-cycle loads/stores and retiring load writebacks itself.

Parameters:
NREGS, 16, number of architectural registers (index width 4)
MEM_LAT, 3, cycles a load/store occupies the memory port (legal 1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
dec_valid  input  1  decode holds a valid instruction
dec_opcode  input  4  instr[15:12]
dec_dest  input  4  instr[11:8]; for store: data source register
dec_src1  input  4  instr[7:4]
dec_src2  input  4  instr[3:0]
dec_memAddr  input  8  instr[7:0], used by load/store
wb_valid  input  1  execute writes back an ALU result this cycle
wb_reg  input  4  ALU writeback register
inuse1  output  1  dec_src1 has a pending write
inuse2  output  1  dec_src2 has a pending write
stall  output  1  hold fetch and decode this cycle
ex_valid  output  1  registered: instruction issued to execute
ex_opcode  output  4  registered opcode of issued instruction
ex_destReg  output  4  registered destination
ld_wb_valid  output  1  one-cycle pulse: load data returns
ld_wb_reg  output  4  load destination register
mem_addr  output  8  address held on memory port while busy
mem_we  output  1  memory port write enable (store in progress)
mem_busy  output  1  memory port occupied

Behaviour:
- Opcode classes: 4'b1110 = LOAD (dest, memAddr); 4'b1111 = STORE (reads dest field as data source, memAddr); all others = ALU (reads src1, src2, writes dest).
- Scoreboard busy[15:0]. Clear view = busy with bit wb_reg masked when wb_valid, and bit ld_wb_reg masked when ld_wb_valid (same-cycle writeback is visible).
- inuse1/inuse2 = clear view at dec_src1/dec_src2. Combinational; driven regardless of opcode.
- Hazard (combinational, only when dec_valid):
  - ALU: clear view set at src1, src2 or dest.
  - LOAD: clear view set at dest, or mem_busy.
  - STORE: clear view set at dest field, or mem_busy.
- stall = dec_valid & hazard. Issue = dec_valid & ~hazard.
- On issue edge: ex_valid<=1, ex_opcode/ex_destReg <= decode fields. Otherwise ex_valid<=0; ex_opcode/ex_destReg hold.
- Busy update each edge:
  - Clear bits for wb and ld_wb.
  - Then set busy[dest] for an issued ALU or LOAD. Set wins over a same-register clear.
- Memory FSM: IDLE, BUSY.
  - IDLE: on LOAD/STORE issue -> BUSY. cnt<=MEM_LAT-1; mem_addr<=dec_memAddr; mem_we<=(STORE); ld_reg<=dest; is_load latched.
  - BUSY: cnt decrements each cycle. At cnt==0 -> IDLE, mem_we<=0.
  - If is_load, ld_wb_valid=1 with ld_wb_reg=ld_reg during that final BUSY cycle (combinational from state). The bit is cleared at that edge.
  - MEM_LAT=1: exactly one BUSY cycle.
- mem_busy = (state==BUSY). A memory op arriving while BUSY stalls. An ALU op may issue while BUSY if its registers are clear.
- wb_valid for a register not marked busy: no effect.
- Reset (any cycle, including mid-load):
  - busy=0, state IDLE, cnt=0.
  - ex_valid=0, ex_opcode=0, ex_destReg=0.
  - mem_addr=0, mem_we=0, ld_wb_reg=0.
  - In-flight load is abandoned; no ld_wb pulse.
  - stall=0 during reset.

Optional Feature:
Macro ISSUE_PERF_CNT_EN. When defined, adds outputs stall_count[15:0] and issue_count[15:0]:
- stall_count increments on each cycle with stall=1.
- issue_count increments on each issue.
- Both saturate at 16'hFFFF and clear on rst.
When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- RAW stall: issue ALU 16'h2331 (dest R3). Next cycle present ALU 16'h4235 (src1 R3) -> inuse1=1, stall=1. Hold until wb_valid, wb_reg=3; that same cycle stall=0 and the instruction issues.
- Load latency (MEM_LAT=3): issue LOAD 16'hE7EE (dest R7, addr 8'hEE) -> mem_busy high 3 cycles, mem_addr=8'hEE, mem_we=0. ld_wb_valid pulses on the 3rd cycle with ld_wb_reg=7; busy[7] is clear afterward.
- Port conflict: LOAD then immediately STORE 16'hF5EF -> store stalls 3 cycles, then issues with mem_we=1, mem_addr=8'hEF, no ld_wb pulse.
- Overlap: during a load to R7, ALU 16'h2121 issues with no stall; ex_valid=1, ex_destReg=1.
- Set/clear collision: wb_valid with wb_reg=3 on the same edge an ALU with dest R3 issues -> busy[3]=1 afterward.
- Reset mid-load: rst=1 in 2nd BUSY cycle -> next edge mem_busy=0, busy=0, no ld_wb_valid, ex_valid=0.
